// File: rtl/keyboard_scanner.sv
// ============================================================================
// keyboard_scanner : per-key sync/debounce + monophonic priority note encoder.
// Optional octave buttons/OCTAVE port enabled by `define KEYBOARD_OCTAVE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module keyboard_scanner #(
  parameter int NUM_KEYS      = 12,
  parameter int BASE_NOTE     = 12,
  parameter int DB_CYCLES     = 1000000,
  parameter int PRIORITY_HIGH = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_KEYS-1:0] KEYS,
  output logic [5:0]          NOTE,
  output logic                NOTE_VALID,
  output logic                NOTE_ON,
  output logic                NOTE_OFF
`ifdef KEYBOARD_OCTAVE_EN
  ,
  input  logic                OCT_UP,
  input  logic                OCT_DN,
  output logic [1:0]          OCTAVE
`endif
);

`ifdef KEYBOARD_OCTAVE_EN
  localparam int NUM_BTN = 2;
`else
  localparam int NUM_BTN = 0;
`endif
  localparam int NUM_IN   = NUM_KEYS + NUM_BTN;
  localparam int CW       = $clog2(DB_CYCLES + 1);
  localparam int TOP_NOTE = BASE_NOTE + NUM_KEYS - 1;

  generate
    if (NUM_KEYS < 1 || NUM_KEYS > 32 || DB_CYCLES < 1 || TOP_NOTE > 63) begin : g_param_err
      $error("keyboard_scanner: illegal parameter combination");
    end
  endgenerate

  logic [NUM_IN-1:0] raw;
`ifdef KEYBOARD_OCTAVE_EN
  assign raw = {OCT_DN, OCT_UP, KEYS};
`else
  assign raw = KEYS;
`endif

  // Synchroniser and debounce state, one lane per key (and octave button)
  logic [NUM_IN-1:0] sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
  logic [CW-1:0]     cnt_q [NUM_IN];
  logic [CW-1:0]     cnt_d [NUM_IN];

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < NUM_IN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CW'(DB_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [6:0] oct_term;

`ifdef KEYBOARD_OCTAVE_EN
  // Highest octave that still keeps the top key within the 6-bit note range
  localparam int OCT_MAX = (TOP_NOTE + 36 <= 63) ? 3 :
                           (TOP_NOTE + 24 <= 63) ? 2 :
                           (TOP_NOTE + 12 <= 63) ? 1 : 0;
  logic [1:0] octave_q, octave_d;
  logic       up_rise, dn_rise;

  always_comb begin
    up_rise  = db_d[NUM_KEYS] & ~db_q[NUM_KEYS];
    dn_rise  = db_d[NUM_KEYS+1] & ~db_q[NUM_KEYS+1];
    octave_d = octave_q;
    if (up_rise && !dn_rise && (octave_q < 2'(OCT_MAX))) begin
      octave_d = octave_q + 2'd1;
    end else if (dn_rise && !up_rise && (octave_q != 2'd0)) begin
      octave_d = octave_q - 2'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) octave_q <= 2'd0;
    else     octave_q <= octave_d;
  end

  assign OCTAVE   = octave_q;
  assign oct_term = 7'(octave_q) * 7'd12;
`else
  assign oct_term = 7'd0;
`endif

  logic       any_held;
  logic [5:0] idx;
  logic [5:0] note_w;

  always_comb begin
    any_held = |db_q[NUM_KEYS-1:0];
    idx      = '0;
    if (PRIORITY_HIGH != 0) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (db_q[i]) idx = 6'(i);
      end
    end else begin
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
        if (db_q[i]) idx = 6'(i);
      end
    end
    note_w = 6'(7'(BASE_NOTE) + {1'b0, idx} + oct_term);
  end

  logic [5:0] note_q, note_d;
  logic       valid_q, valid_d, on_q, on_d, off_q, off_d;

  // Legato moves and octave retriggers produce NOTE_ON only; OFF needs an empty set
  always_comb begin
    note_d  = any_held ? note_w : note_q;
    valid_d = any_held;
    on_d    = any_held && (!valid_q || (note_w != note_q));
    off_d   = !any_held && valid_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      note_q  <= '0;
      valid_q <= 1'b0;
      on_q    <= 1'b0;
      off_q   <= 1'b0;
    end else begin
      note_q  <= note_d;
      valid_q <= valid_d;
      on_q    <= on_d;
      off_q   <= off_d;
    end
  end

  assign NOTE       = note_q;
  assign NOTE_VALID = valid_q;
  assign NOTE_ON    = on_q;
  assign NOTE_OFF   = off_q;

endmodule

`default_nettype wire

// File: tb/tb_keyboard_scanner.sv
// ============================================================================
// tb_keyboard_scanner : table-driven directed bench for keyboard_scanner.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_keyboard_scanner;

  logic        CLK = 1'b0;
  logic        RST;
  logic [11:0] KEYS;
  logic [5:0]  NOTE;
  logic        NOTE_VALID, NOTE_ON, NOTE_OFF;
`ifdef KEYBOARD_OCTAVE_EN
  logic        OCT_UP, OCT_DN;
  logic [1:0]  OCTAVE;
`endif

  always #5 CLK = ~CLK;

  keyboard_scanner #(
    .NUM_KEYS(12), .BASE_NOTE(12), .DB_CYCLES(4), .PRIORITY_HIGH(1)
  ) dut (
    .CLK(CLK), .RST(RST), .KEYS(KEYS),
    .NOTE(NOTE), .NOTE_VALID(NOTE_VALID), .NOTE_ON(NOTE_ON), .NOTE_OFF(NOTE_OFF)
`ifdef KEYBOARD_OCTAVE_EN
    , .OCT_UP(OCT_UP), .OCT_DN(OCT_DN), .OCTAVE(OCTAVE)
`endif
  );

  typedef struct {
    logic [11:0] keys;
    int          n;
    int          note;
    logic        valid;
    logic        on;
    logic        off;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  int checks = 0;
  int errors = 0;
  int pulses;
  int offs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

`ifdef KEYBOARD_OCTAVE_EN
  task automatic press_oct(input logic up, input logic dn, input int exp_oct,
                           input int exp_note, input logic exp_on);
    OCT_UP = up;
    OCT_DN = dn;
    pulses = 0;
    for (int e = 0; e < 6; e++) begin
      step();
      pulses += int'(NOTE_ON | NOTE_OFF);
    end
    check("oct early pulses", pulses, 0);
    step();
    check("oct octave", OCTAVE, exp_oct);
    check("oct note", NOTE, exp_note);
    check("oct note_on", NOTE_ON, exp_on);
    check("oct note_off", NOTE_OFF, 0);
    OCT_UP = 1'b0;
    OCT_DN = 1'b0;
    pulses = 0;
    for (int e = 0; e < 10; e++) begin
      step();
      pulses += int'(NOTE_ON | NOTE_OFF);
    end
    check("oct release pulses", pulses, 0);
    check("oct release octave", OCTAVE, exp_oct);
  endtask
`endif

  initial begin
    //           keys    n  note v  on off
    tbl[0]  = '{12'h008, 6,  0, 0, 0, 0};
    tbl[1]  = '{12'h008, 1, 15, 1, 1, 0};
    tbl[2]  = '{12'h008, 1, 15, 1, 0, 0};
    tbl[3]  = '{12'h000, 6, 15, 1, 0, 0};
    tbl[4]  = '{12'h000, 1, 15, 0, 0, 1};
    tbl[5]  = '{12'h000, 1, 15, 0, 0, 0};
    tbl[6]  = '{12'h020, 3, 15, 0, 0, 0};
    tbl[7]  = '{12'h000,10, 15, 0, 0, 0};
    tbl[8]  = '{12'h020, 7, 17, 1, 1, 0};
    tbl[9]  = '{12'h000, 3, 17, 1, 0, 0};
    tbl[10] = '{12'h020,10, 17, 1, 0, 0};
    tbl[11] = '{12'h000, 7, 17, 0, 0, 1};
    tbl[12] = '{12'h004, 7, 14, 1, 1, 0};
    tbl[13] = '{12'h204, 6, 14, 1, 0, 0};
    tbl[14] = '{12'h204, 1, 21, 1, 1, 0};
    tbl[15] = '{12'h204, 1, 21, 1, 0, 0};
    tbl[16] = '{12'h004, 7, 14, 1, 1, 0};
    tbl[17] = '{12'h004, 1, 14, 1, 0, 0};
    tbl[18] = '{12'h000, 7, 14, 0, 0, 1};
    tbl[19] = '{12'h080, 7, 19, 1, 1, 0};
    tbl[20] = '{12'h002, 7, 13, 1, 1, 0};
    tbl[21] = '{12'h000, 7, 13, 0, 0, 1};
    tbl[22] = '{12'h801, 7, 23, 1, 1, 0};
    tbl[23] = '{12'h000, 7, 23, 0, 0, 1};

    RST  = 1'b1;
    KEYS = '0;
`ifdef KEYBOARD_OCTAVE_EN
    OCT_UP = 1'b0;
    OCT_DN = 1'b0;
`endif
    step();
    step();
    check("reset note", NOTE, 0);
    check("reset valid", NOTE_VALID, 0);
    check("reset on", NOTE_ON, 0);
    check("reset off", NOTE_OFF, 0);
`ifdef KEYBOARD_OCTAVE_EN
    check("reset octave", OCTAVE, 0);
`endif
    RST = 1'b0;

    pulses = 0;
    for (int e = 0; e < 100; e++) begin
      step();
      pulses += int'(NOTE_VALID | NOTE_ON | NOTE_OFF);
      if (NOTE != 6'd0) pulses++;
    end
    check("idle 100 cycles activity", pulses, 0);

    for (int r = 0; r < NV; r++) begin
      KEYS   = tbl[r].keys;
      pulses = 0;
      for (int e = 0; e < tbl[r].n - 1; e++) begin
        step();
        pulses += int'(NOTE_ON | NOTE_OFF);
      end
      step();
      check($sformatf("row%0d early pulses", r), pulses, 0);
      check($sformatf("row%0d note", r), NOTE, tbl[r].note);
      check($sformatf("row%0d valid", r), NOTE_VALID, tbl[r].valid);
      check($sformatf("row%0d on", r), NOTE_ON, tbl[r].on);
      check($sformatf("row%0d off", r), NOTE_OFF, tbl[r].off);
    end

    // Reset mid-note and mid-debounce
    KEYS = 12'h400;
    for (int e = 0; e < 7; e++) step();
    check("pre-reset note", NOTE, 22);
    check("pre-reset on", NOTE_ON, 1);
    KEYS = 12'h010;
    offs = 0;
    for (int e = 0; e < 4; e++) begin
      step();
      offs += int'(NOTE_OFF);
    end
    RST = 1'b1;
    #1;
    check("async reset note", NOTE, 0);
    check("async reset valid", NOTE_VALID, 0);
    step();
    offs += int'(NOTE_OFF);
    check("held reset on", NOTE_ON, 0);
    RST = 1'b0;
    pulses = 0;
    for (int e = 0; e < 6; e++) begin
      step();
      pulses += int'(NOTE_ON | NOTE_VALID);
      offs   += int'(NOTE_OFF);
    end
    check("post-reset early activity", pulses, 0);
    step();
    offs += int'(NOTE_OFF);
    check("post-reset note", NOTE, 16);
    check("post-reset valid", NOTE_VALID, 1);
    check("post-reset on", NOTE_ON, 1);
    check("reset emitted note_off", offs, 0);

`ifdef KEYBOARD_OCTAVE_EN
    KEYS = 12'h001;
    for (int e = 0; e < 7; e++) step();
    check("key0 note", NOTE, 12);
    check("key0 on", NOTE_ON, 1);
    press_oct(1'b1, 1'b0, 1, 24, 1'b1);
    press_oct(1'b1, 1'b0, 2, 36, 1'b1);
    press_oct(1'b1, 1'b0, 3, 48, 1'b1);
    press_oct(1'b1, 1'b0, 3, 48, 1'b0);
    press_oct(1'b1, 1'b1, 3, 48, 1'b0);
    press_oct(1'b0, 1'b1, 2, 36, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keyboard_scanner.md
# keyboard_scanner

Multi-key front end for the synthesiser: samples NUM_KEYS raw key inputs, synchronises and debounces each one independently, and resolves the held set to a single monophonic note number with one-cycle note-on/note-off event pulses. It sits between the board key pins and the tone generator. It replaces the single-key decoder/debounce pairing with one parametrised block.

## Interface
- NUM_KEYS, 12: number of key inputs; 1..32.
- BASE_NOTE, 12: note number of key index 0; elaboration error if BASE_NOTE + NUM_KEYS - 1 > 63.
- DB_CYCLES, 1000000: consecutive stable synchronised cycles required to accept a level change; must be at least 1.
- PRIORITY_HIGH, 1: 1 = highest held index wins, 0 = lowest held index wins.
- CLK  in  1  sole clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- KEYS  in  NUM_KEYS  raw key levels, 1 = pressed, asynchronous to CLK.
- NOTE  out  6  active note number.
- NOTE_VALID  out  1  high while at least one debounced key is held.
- NOTE_ON  out  1  one-cycle pulse when a new note becomes active.
- NOTE_OFF  out  1  one-cycle pulse when the last held key is released.
- OCT_UP, OCT_DN  in  1 each  raw octave buttons (only with KEYBOARD_OCTAVE_EN).
- OCTAVE  out  2  current octave offset 0..3 (only with KEYBOARD_OCTAVE_EN).

## Operation
- Per key: 2-flop synchroniser, then a debounced state db[i] with counter of width $clog2(DB_CYCLES+1).
- Counter: clears when sync level equals db[i]; otherwise increments. When it reaches DB_CYCLES, db[i] takes the sync level and the counter clears. A glitch shorter than DB_CYCLES cycles never changes db[i].
- Encoder: selects idx from db vector per PRIORITY_HIGH. Computes note = BASE_NOTE + idx + 12*OCTAVE in 7 bits, then truncates to 6 bits; range is guaranteed by the octave rules.
- Registered outputs, updated each cycle from db vector:
  - any held: NOTE <= note, NOTE_VALID <= 1. NOTE_ON <= 1 if previous NOTE_VALID was 0 or note differs from current NOTE.
  - none held: NOTE holds last value, NOTE_VALID <= 0. NOTE_OFF <= 1 if previous NOTE_VALID was 1.
- Legato: moving between held keys pulses NOTE_ON only, never NOTE_OFF.
- Simultaneous debounced changes in one cycle resolve on the combined vector. Press of key A plus release of held key B in the same cycle gives NOTE_ON for A only.
- NOTE_ON and NOTE_OFF are never high in the same cycle.
- Reset values: all synchroniser flops, db states, counters, NOTE, NOTE_VALID, NOTE_ON, NOTE_OFF and OCTAVE are 0.
- Reset asserted mid-debounce or mid-note aborts all state. No NOTE_OFF is emitted on reset.

## Timing
- Raw key change held stable: synchroniser adds 2 edges; db[i] flips on edge DB_CYCLES+2 after the first edge sampling the new level.
- NOTE, NOTE_VALID and pulses register one edge later, so total latency is DB_CYCLES+3 edges.
- Pulses are exactly one CLK cycle wide.
- Back-to-back pulses on consecutive cycles are legal, e.g. a NOTE_ON from an octave change followed by a key change.

## Configuration
- KEYBOARD_OCTAVE_EN defined:
  - OCT_UP, OCT_DN and OCTAVE ports exist; each button uses the same synchroniser/debounce path as keys.
  - A debounced rising edge of OCT_UP increments OCTAVE, ignored at 3 or when BASE_NOTE + NUM_KEYS - 1 + 12*(OCTAVE+1) > 63.
  - A debounced rising edge of OCT_DN decrements OCTAVE, ignored at 0. Both rising in the same cycle: no change.
  - Octave change while a note is held updates NOTE on the next edge with a NOTE_ON pulse (retrigger).
- KEYBOARD_OCTAVE_EN not defined: the three ports are absent and the octave term is constant 0.

## Test plan
Bench parameters: NUM_KEYS=12, BASE_NOTE=12, DB_CYCLES=4, PRIORITY_HIGH=1.
- Reset, no keys -> NOTE=0, NOTE_VALID=0, no pulses for 100 cycles.
- KEYS[3] pressed and held -> on edge 7: NOTE=15, NOTE_VALID=1, NOTE_ON for one cycle. Release -> 7 edges later NOTE_VALID=0, NOTE_OFF one cycle, NOTE stays 15.
- KEYS[5] 3-cycle high glitch, then a 3-cycle low glitch while held -> no NOTE_VALID change, no pulses.
- Hold KEYS[2], then add KEYS[9] -> NOTE 14 then 21 with a NOTE_ON at each change. Release KEYS[9] -> NOTE=14, NOTE_ON, no NOTE_OFF.
- With KEYBOARD_OCTAVE_EN, KEYS[0] held, OCT_UP pressed four times -> OCTAVE 1, 2, 3, 3, NOTE 24, 36, 48, with a NOTE_ON per accepted step. OCT_DN and OCT_UP together -> OCTAVE unchanged.
- Assert RST while KEYS[4] is debounced halfway, then deassert with KEYS[4] still held -> all outputs 0 during reset. After deassertion, NOTE=16 with NOTE_ON exactly 7 edges after the first sampling edge.
